wb_commit_unit: RTL and testbench

- Register-file writer: merges results from the single-cycle ALU path and a long-latency unit (multiply/load) into the one register-file write port (regWrite/writeReg/writeData).
- Long results are buffered in a small FIFO.
- A 32-entry pending scoreboard tells decode which registers still await a long result.
- Sits between execute/memory and the register file.

---
 rtl/wb_commit_if.sv | 42 ++++
 rtl/wb_commit_unit.sv | 107 ++++++++++
 tb/tb_wb_commit_unit.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_commit_if.sv
// Bundle between execute/memory, decode and the register-file write port for wb_commit_unit.
// slave = the commit unit, master = the surrounding pipeline.
interface wb_commit_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic                     aluValid;
    logic [REG_AW-1:0]        aluReg;
    logic [DATA_W-1:0]        aluData;
    logic                     issueValid;
    logic [REG_AW-1:0]        issueReg;
    logic                     longValid;
    logic [REG_AW-1:0]        longReg;
    logic [DATA_W-1:0]        longData;
    logic                     longReady;
    logic                     regWrite;
    logic [REG_AW-1:0]        writeReg;
    logic [DATA_W-1:0]        writeData;
    logic [REG_AW-1:0]        queryReg1;
    logic [REG_AW-1:0]        queryReg2;
    logic                     pending1;
    logic                     pending2;
    logic [$clog2(DEPTH):0]   fifoCount;
    logic                     fwdValid;
    logic [REG_AW-1:0]        fwdReg;
    logic [DATA_W-1:0]        fwdData;

    modport slave (
        input  aluValid, aluReg, aluData, issueValid, issueReg,
               longValid, longReg, longData, queryReg1, queryReg2,
        output longReady, regWrite, writeReg, writeData,
               pending1, pending2, fifoCount, fwdValid, fwdReg, fwdData
    );

    modport master (
        output aluValid, aluReg, aluData, issueValid, issueReg,
               longValid, longReg, longData, queryReg1, queryReg2,
        input  longReady, regWrite, writeReg, writeData,
               pending1, pending2, fifoCount, fwdValid, fwdReg, fwdData
    );
endinterface

// File: rtl/wb_commit_unit.sv
// Register-file writer: ALU results win, long results drain from a FIFO, pending scoreboard for decode.
// Optional macro WB_BYPASS_EN exposes the selected commit combinationally on fwdValid/fwdReg/fwdData.
module wb_commit_unit #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_commit_if.slave   bus
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int NREG = 1 << REG_AW;

    logic [REG_AW-1:0] fifo_reg  [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pending_nxt;

    logic              alu_commit;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              sel_valid;
    logic [REG_AW-1:0] sel_reg;
    logic [DATA_W-1:0] sel_data;

    always_comb begin
        alu_commit = bus.aluValid && (bus.aluReg != '0);
        fifo_empty = (count == '0);
        fifo_full  = (count == CW'(DEPTH));
        pop        = !alu_commit && !fifo_empty;
        // A long result to reg 0 completes its handshake but is dropped.
        push       = bus.longValid && !fifo_full && (bus.longReg != '0);
        sel_valid  = alu_commit || pop;
        sel_reg    = '0;
        sel_data   = '0;
        if (alu_commit) begin
            sel_reg  = bus.aluReg;
            sel_data = bus.aluData;
        end else if (pop) begin
            sel_reg  = fifo_reg[rd_ptr];
            sel_data = fifo_data[rd_ptr];
        end
    end

    // Clear from the pop is applied first so a same-cycle issue to that register wins.
    always_comb begin
        pending_nxt = pending;
        if (pop)
            pending_nxt[fifo_reg[rd_ptr]] = 1'b0;
        if (bus.issueValid && (bus.issueReg != '0))
            pending_nxt[bus.issueReg] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            pending       <= '0;
            bus.regWrite  <= 1'b0;
            bus.writeReg  <= '0;
            bus.writeData <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count   <= count + CW'(push) - CW'(pop);
            pending <= pending_nxt;
            bus.regWrite <= sel_valid;
            if (sel_valid) begin
                bus.writeReg  <= sel_reg;
                bus.writeData <= sel_data;
            end
        end
    end

    // Storage needs no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_reg[wr_ptr]  <= bus.longReg;
            fifo_data[wr_ptr] <= bus.longData;
        end
    end

    assign bus.longReady = !fifo_full;
    assign bus.fifoCount = count;
    assign bus.pending1  = (bus.queryReg1 != '0) && pending[bus.queryReg1];
    assign bus.pending2  = (bus.queryReg2 != '0) && pending[bus.queryReg2];

`ifdef WB_BYPASS_EN
    assign bus.fwdValid = sel_valid;
    assign bus.fwdReg   = sel_reg;
    assign bus.fwdData  = sel_data;
`else
    assign bus.fwdValid = 1'b0;
    assign bus.fwdReg   = '0;
    assign bus.fwdData  = '0;
`endif
endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed self-checking bench for wb_commit_unit (DEPTH=4, DATA_W=32, REG_AW=5).
module tb_wb_commit_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    wb_commit_if #(.DEPTH(4), .DATA_W(32), .REG_AW(5)) bus ();

    wb_commit_unit #(.DEPTH(4), .DATA_W(32), .REG_AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_fwd(input string tag, input logic v, input logic [4:0] r, input logic [31:0] d);
`ifdef WB_BYPASS_EN
        check({tag, ".fwdValid"}, 64'(bus.fwdValid), 64'(v));
        check({tag, ".fwdReg"},   64'(bus.fwdReg),   64'(r));
        check({tag, ".fwdData"},  64'(bus.fwdData),  64'(d));
`else
        check({tag, ".fwdValid"}, 64'(bus.fwdValid), 64'(0));
        check({tag, ".fwdReg"},   64'(bus.fwdReg),   64'(0));
        check({tag, ".fwdData"},  64'(bus.fwdData),  64'(0));
`endif
    endtask

    task automatic check_wr(input string tag, input logic we, input logic [4:0] r, input logic [31:0] d);
        check({tag, ".regWrite"},  64'(bus.regWrite),  64'(we));
        check({tag, ".writeReg"},  64'(bus.writeReg),  64'(r));
        check({tag, ".writeData"}, 64'(bus.writeData), 64'(d));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.aluValid   = 1'b0; bus.aluReg   = '0; bus.aluData  = '0;
        bus.issueValid = 1'b0; bus.issueReg = '0;
        bus.longValid  = 1'b0; bus.longReg  = '0; bus.longData = '0;
    endtask

    task automatic alu(input logic v, input logic [4:0] r, input logic [31:0] d);
        bus.aluValid = v; bus.aluReg = r; bus.aluData = d;
    endtask

    task automatic lng(input logic v, input logic [4:0] r, input logic [31:0] d);
        bus.longValid = v; bus.longReg = r; bus.longData = d;
    endtask

    task automatic iss(input logic v, input logic [4:0] r);
        bus.issueValid = v; bus.issueReg = r;
    endtask

    initial begin
        idle_inputs();
        bus.queryReg1 = '0;
        bus.queryReg2 = '0;

        // reset state, with pushes/issues presented while in reset
        lng(1'b1, 5'd7, 32'h77);
        iss(1'b1, 5'd7);
        bus.queryReg1 = 5'd7;
        step();
        check_wr("rst", 1'b0, 5'd0, 32'd0);
        check("rst.fifoCount", 64'(bus.fifoCount), 64'd0);
        check("rst.pending1",  64'(bus.pending1),  64'd0);
        check("rst.longReady", 64'(bus.longReady), 64'd1);
        idle_inputs();
        rst_n = 1'b1;
        step();

        // ALU only
        alu(1'b1, 5'd5, 32'h0000_00AB);
        #1;
        check_fwd("alu5", 1'b1, 5'd5, 32'hAB);
        step();
        check_wr("alu5", 1'b1, 5'd5, 32'hAB);
        alu(1'b1, 5'd0, 32'hFF);
        #1;
        check_fwd("alu0", 1'b0, 5'd0, 32'd0);
        step();
        check_wr("alu0", 1'b0, 5'd5, 32'hAB);
        alu(1'b0, 5'd0, 32'd0);

        // ALU/long priority and scoreboard clear on pop
        bus.queryReg1 = 5'd8;
        iss(1'b1, 5'd8);
        step();
        iss(1'b0, 5'd0);
        check("prio.pend_after_issue", 64'(bus.pending1), 64'd1);
        alu(1'b1, 5'd3, 32'h33);
        lng(1'b1, 5'd8, 32'h1234);
        step();
        lng(1'b0, 5'd0, 32'd0);
        check_wr("prio.c1", 1'b1, 5'd3, 32'h33);
        check("prio.count1", 64'(bus.fifoCount), 64'd1);
        for (int i = 2; i <= 3; i++) begin
            alu(1'b1, 5'd3, 32'h30 + 32'(i));
            step();
            check_wr($sformatf("prio.c%0d", i), 1'b1, 5'd3, 32'h30 + 32'(i));
            check($sformatf("prio.pend%0d", i), 64'(bus.pending1), 64'd1);
            check($sformatf("prio.count%0d", i), 64'(bus.fifoCount), 64'd1);
        end
        alu(1'b0, 5'd0, 32'd0);
        #1;
        check_fwd("prio.pop", 1'b1, 5'd8, 32'h1234);
        step();
        check_wr("prio.pop", 1'b1, 5'd8, 32'h1234);
        check("prio.count_pop", 64'(bus.fifoCount), 64'd0);
        check("prio.pend_pop",  64'(bus.pending1),  64'd0);
        step();
        check_wr("prio.idle", 1'b0, 5'd8, 32'h1234);

        // fill the FIFO under continuous ALU writes
        bus.queryReg2 = 5'd10;
        for (int i = 0; i < 4; i++) begin
            alu(1'b1, 5'd3, 32'h100 + 32'(i));
            lng(1'b1, 5'(10 + i), 32'hA0 + 32'(i));
            iss(1'b1, 5'(10 + i));
            step();
        end
        iss(1'b0, 5'd0);
        check("full.count",     64'(bus.fifoCount), 64'd4);
        check("full.longReady", 64'(bus.longReady), 64'd0);
        check("full.pend10",    64'(bus.pending2),  64'd1);
        lng(1'b1, 5'd14, 32'hA4);
        alu(1'b1, 5'd3, 32'h200);
        step();
        check("full.hold_count", 64'(bus.fifoCount), 64'd4);
        check_wr("full.alu", 1'b1, 5'd3, 32'h200);
        alu(1'b0, 5'd0, 32'd0);
        // pop with a full FIFO: no push this cycle
        step();
        check_wr("drain.r10", 1'b1, 5'd10, 32'hA0);
        check("drain.count10", 64'(bus.fifoCount), 64'd3);
        check("drain.ready10", 64'(bus.longReady), 64'd1);
        check("drain.pend10",  64'(bus.pending2),  64'd0);
        // held result transfers now while r11 pops
        step();
        lng(1'b0, 5'd0, 32'd0);
        check_wr("drain.r11", 1'b1, 5'd11, 32'hA1);
        check("drain.count11", 64'(bus.fifoCount), 64'd3);
        for (int i = 12; i <= 14; i++) begin
            step();
            check_wr($sformatf("drain.r%0d", i), 1'b1, 5'(i), 32'hA0 + 32'(i - 10));
        end
        check("drain.empty", 64'(bus.fifoCount), 64'd0);
        step();
        check_wr("drain.idle", 1'b0, 5'd14, 32'hA4);

        // same-cycle set and clear on r9
        bus.queryReg1 = 5'd9;
        alu(1'b1, 5'd3, 32'h300);
        lng(1'b1, 5'd9, 32'h99);
        iss(1'b1, 5'd9);
        step();
        lng(1'b0, 5'd0, 32'd0);
        alu(1'b0, 5'd0, 32'd0);
        check("sc.pend_before", 64'(bus.pending1), 64'd1);
        step();
        iss(1'b0, 5'd0);
        check_wr("sc.pop9", 1'b1, 5'd9, 32'h99);
        check("sc.pend_kept", 64'(bus.pending1), 64'd1);

        // long result to reg 0: accepted, not queued
        lng(1'b1, 5'd0, 32'hDEAD);
        #1;
        check("r0.longReady", 64'(bus.longReady), 64'd1);
        step();
        lng(1'b0, 5'd0, 32'd0);
        check("r0.count", 64'(bus.fifoCount), 64'd0);
        step();
        check("r0.noWrite", 64'(bus.regWrite), 64'd0);

        // asynchronous reset mid-stream with two buffered results
        bus.queryReg1 = 5'd20;
        for (int i = 0; i < 2; i++) begin
            alu(1'b1, 5'd3, 32'h400);
            lng(1'b1, 5'(20 + i), 32'hB0 + 32'(i));
            iss(1'b1, 5'(20 + i));
            step();
        end
        check("mid.count", 64'(bus.fifoCount), 64'd2);
        check("mid.pend",  64'(bus.pending1),  64'd1);
        check("mid.we",    64'(bus.regWrite),  64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.regWrite",  64'(bus.regWrite),  64'd0);
        check("arst.fifoCount", 64'(bus.fifoCount), 64'd0);
        check("arst.pending1",  64'(bus.pending1),  64'd0);
        idle_inputs();
        #1;
        rst_n = 1'b1;
        step();
        step();
        check("post.count", 64'(bus.fifoCount), 64'd0);
        check_wr("post.noWrite", 1'b0, 5'd0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
